fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Issue-side controller for the floating-point ALU datapath.
- Accepts one FP operation request at a time over a valid/ready handshake and drives the ALU's operands and opcode from registers, held stable for the whole operation.
- Waits an opcode-dependent number of cycles, then captures the ALU result.
- Returns the result with its destination tag over a valid/ready response channel to the writeback stage.

Parameters:
- TAG_W, 5, width of destination-register tag carried with each request.
- DIV_LAT, 4, cycles from accept to result capture for DIV; must be 1..255.
- SQRT_LAT, 4, cycles from accept to result capture for SQRT; must be 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_op  in  5  opcode (package encoding).
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  destination tag.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_op  out  5  registered opcode to ALU.
- alu_result  in  32  ALU output.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  captured result.
- resp_tag  out  TAG_W  tag of the completed request.
- resp_err  out  1  opcode was illegal.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; cnt=0.
  - alu_a, alu_b, alu_op, resp_data, resp_tag: all 0.
  - resp_valid=0, resp_err=0.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). It is combinational and never depends on req_valid.
- Accept (handshake at edge T):
  - Latch req_a/req_b/req_op into alu_a/alu_b/alu_op, and req_tag into an internal tag register.
  - Load cnt = L-1, where L = DIV_LAT for DIV, SQRT_LAT for SQRT, and 1 for every other legal opcode.
  - Go to EXEC.
- Illegal opcode (req_op > 10) on accept:
  - Go to EXEC with L=1 and alu_op driven 0.
  - At capture: resp_data=0, resp_err=1.
- EXEC:
  - If cnt != 0: cnt decrements each edge.
  - If cnt == 0: at that edge capture resp_data=alu_result (or 0 if illegal), resp_tag, and resp_err. Set resp_valid=1 and go to RESP.
  - Net effect: resp_valid rises exactly L cycles after the accept edge.
- alu_a/alu_b/alu_op change only on accept. They hold from accept until the next accept, which the clocked DIV/SQRT units require.
- RESP:
  - resp_valid=1; resp_data, resp_tag and resp_err are held stable until the handshake.
  - Handshake with no new request: resp_valid=0 and go to IDLE.
  - Handshake with req_valid=1 in the same cycle: the new request is accepted in that edge and the state goes straight to EXEC. This gives no bubble.
- At most one operation is in flight; no reordering.
- rst asserted mid-EXEC or mid-RESP: the operation is abandoned and no response is produced.
- req_valid deasserting before acceptance is legal and has no effect.
- cnt is 8 bits wide.

Decomposition:
- Package fpu_pkg holds:
  - Opcode localparams: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_SQRT=4, OP_MIN=5, OP_MAX=6, OP_LT=7, OP_EQ=8, OP_LEQ=9, OP_CONV=10, OP_LAST=10.
  - State encoding.
  - The function op_latency(op, DIV_LAT, SQRT_LAT).
- No sub-module. FSM, counter and response registers live in one module.
- The ALU is instantiated alongside this block by the parent, not inside it.

Test Plan:
- ADD, A=0x3F800000 (1.0), B=0x40000000 (2.0), tag=7, resp_ready=1 -> resp_valid exactly 1 cycle after accept; resp_data=0x40400000, resp_tag=7, resp_err=0.
- DIV, DIV_LAT=4, A=0x40C00000 (6.0), B=0x40000000 -> req_ready=0 and busy=1 for 4 cycles; alu_a/alu_b stable throughout; resp_data=0x40400000.
- SQRT of 0x40800000 (4.0) with resp_ready held low 3 cycles -> resp_valid stays 1; resp_data=0x40000000 held; req_ready=0 until resp_ready=1.
- In RESP, drive resp_ready=1 and a new MUL request (0x40000000 × 0x40400000) in the same cycle -> both handshakes complete at one edge; next response 0x40C00000 arrives 1 cycle later; no IDLE cycle in between.
- req_op=20 -> response after 1 cycle with resp_err=1, resp_data=0, alu_op=0.
- rst pulsed 2 cycles into a DIV -> all outputs 0 immediately (async); no response appears; next ADD request completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue sequencer: opcode encoding, FSM states
// and the per-opcode latency lookup.
package fpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_SQRT = 5'd4;
    localparam logic [4:0] OP_MIN  = 5'd5;
    localparam logic [4:0] OP_MAX  = 5'd6;
    localparam logic [4:0] OP_LT   = 5'd7;
    localparam logic [4:0] OP_EQ   = 5'd8;
    localparam logic [4:0] OP_LEQ  = 5'd9;
    localparam logic [4:0] OP_CONV = 5'd10;
    localparam logic [4:0] OP_LAST = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Cycles from accept to result capture; single-cycle unless DIV/SQRT.
    function automatic logic [7:0] op_latency(input logic [4:0] op,
                                              input int div_lat,
                                              input int sqrt_lat);
        logic [7:0] lat;
        lat = 8'd1;
        if (op == OP_DIV)
            lat = 8'(div_lat);
        else if (op == OP_SQRT)
            lat = 8'(sqrt_lat);
        return lat;
    endfunction

endpackage

// File: rtl/fpu_op_sequencer.sv
// Issue-side controller for the FP ALU: holds operands/opcode stable for the
// whole operation, waits the opcode latency, and returns the tagged result.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no operation in flight, ready for a request
// ST_EXEC | ALU inputs held, cnt counting down to result capture
// ST_RESP | result held on the response channel until accepted
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int TAG_W    = 5,
    parameter int DIV_LAT  = 4,
    parameter int SQRT_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_op,
    input  logic [31:0]      alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             busy
);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [TAG_W-1:0]   tag_q;
    logic               illegal_q;
    logic               req_illegal;
    logic               accept;
    logic               capture;

    assign req_ready   = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
    assign accept      = req_valid && req_ready;
    assign capture     = (state_q == ST_EXEC) && (cnt_q == 8'd0);
    assign req_illegal = (req_op > OP_LAST);
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == 8'd0) state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = req_valid ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            tag_q      <= '0;
            illegal_q  <= 1'b0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_op     <= 5'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Illegal opcodes still take one EXEC cycle so every request gets a response.
            if (accept) begin
                alu_a     <= req_a;
                alu_b     <= req_b;
                alu_op    <= req_illegal ? 5'd0 : req_op;
                tag_q     <= req_tag;
                illegal_q <= req_illegal;
                cnt_q     <= req_illegal ? 8'd0
                                         : op_latency(req_op, DIV_LAT, SQRT_LAT) - 8'd1;
            end else if ((state_q == ST_EXEC) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (capture) begin
                resp_valid <= 1'b1;
                resp_data  <= illegal_q ? 32'd0 : alu_result;
                resp_tag   <= tag_q;
                resp_err   <= illegal_q;
            end else if ((state_q == ST_RESP) && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: table-driven single operations,
// hand sequences for backpressure, back-to-back issue and mid-operation reset.
module tb_fpu_op_sequencer;
    import fpu_pkg::*;

    localparam int TAG_W    = 5;
    localparam int DIV_LAT  = 4;
    localparam int SQRT_LAT = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_op;
    logic [31:0]      alu_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    typedef struct {
        logic [4:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [31:0]      data;
        logic             err;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[9];

    fpu_op_sequencer #(.TAG_W(TAG_W), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: exact IEEE results for the test-plan operands, otherwise an
    // operand-dependent scramble so wrongly latched operands show up.
    function automatic logic [31:0] alu_model(input logic [4:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == OP_DIV && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (op == OP_SQRT && a == 32'h40800000)                      return 32'h40000000;
        if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a ^ {b[15:0], b[31:16]} ^ {27'd0, op} ^ 32'h5A5A0000;
    endfunction

    always_comb alu_result = alu_model(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got data %0h tag %0h with no pending request",
                         resp_data, resp_tag);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
                chk("resp_err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic drive_req(input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [TAG_W-1:0] tag,
                            input logic err);
        exp_t e;
        e.data = data;
        e.tag  = tag;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp_valid(input string name, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 300);
        if (!resp_valid) chk({name, "_timeout"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        @(posedge clk); #1;
        drive_req(v.op, v.a, v.b, v.tag);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        push_exp(v.data, v.tag, v.err);
        #1;
        req_valid = 1'b0;
        chk("alu_op", 32'(alu_op), 32'(v.err ? 5'd0 : v.op));
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!resp_valid && lat < 300) begin
                chk("exec_busy", 32'(busy), 32'd1);
                chk("exec_req_ready", 32'(req_ready), 32'd0);
                chk("exec_alu_a_hold", alu_a, v.a);
                chk("exec_alu_b_hold", alu_b, v.b);
            end
        end while (!resp_valid && lat < 300);
        chk("latency", 32'(lat), 32'(v.lat));
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{OP_ADD,  32'h3F800000, 32'h40000000, 5'd7,  1,        32'h40400000, 1'b0};
        vecs[1] = '{OP_DIV,  32'h40C00000, 32'h40000000, 5'd2,  DIV_LAT,  32'h40400000, 1'b0};
        vecs[2] = '{OP_SQRT, 32'h40800000, 32'h00000000, 5'd5,  SQRT_LAT, 32'h40000000, 1'b0};
        vecs[3] = '{OP_SUB,  32'h12345678, 32'h0F0F0F0F, 5'd30, 1,
                    alu_model(OP_SUB, 32'h12345678, 32'h0F0F0F0F), 1'b0};
        vecs[4] = '{OP_MIN,  32'hC0000000, 32'h3F000000, 5'd12, 1,
                    alu_model(OP_MIN, 32'hC0000000, 32'h3F000000), 1'b0};
        vecs[5] = '{OP_CONV, 32'hDEADBEEF, 32'h00C0FFEE, 5'd31, 1,
                    alu_model(OP_CONV, 32'hDEADBEEF, 32'h00C0FFEE), 1'b0};
        vecs[6] = '{5'd11,   32'h11111111, 32'h22222222, 5'd4,  1, 32'h0, 1'b1};
        vecs[7] = '{5'd20,   32'h3F800000, 32'h40000000, 5'd17, 1, 32'h0, 1'b1};
        vecs[8] = '{5'd31,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  1, 32'h0, 1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 5'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_tag    = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Backpressure on a SQRT result: response must hold until accepted.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        drive_req(OP_SQRT, 32'h40800000, 32'h00000000, 5'd3);
        @(posedge clk);
        push_exp(32'h40000000, 5'd3, 1'b0);
        #1;
        req_valid = 1'b0;
        wait_resp_valid("sqrt_hold", lat);
        for (int i = 0; i < 3; i++) begin
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp_data", resp_data, 32'h40000000);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", 32'(resp_valid), 32'd0);
        chk("hold_release_busy", 32'(busy), 32'd0);

        // Response handshake and new accept on the same edge.
        resp_ready = 1'b0;
        drive_req(OP_ADD, 32'h3F800000, 32'h40000000, 5'd1);
        @(posedge clk);
        push_exp(32'h40400000, 5'd1, 1'b0);
        #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_first_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        drive_req(OP_MUL, 32'h40000000, 32'h40400000, 5'd9);
        #1;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        push_exp(32'h40C00000, 5'd9, 1'b0);
        #1;
        req_valid = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_valid_low", 32'(resp_valid), 32'd0);
        chk("b2b_alu_op", 32'(alu_op), 32'(OP_MUL));
        @(posedge clk); #1;
        chk("b2b_second_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #1;

        // Async reset two cycles into a DIV abandons it.
        drive_req(OP_DIV, 32'h40C00000, 32'h40000000, 5'd6);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_tag", 32'(resp_tag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("arst_no_response", 32'(seen), 32'd0);
        run_vec(vecs[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
